// File: rtl/dst_hazard_pipe.sv
// dst_hazard_pipe: destination/Tnew tracking pipe with D-stage hazard unit.
// Decodes the write register at issue into E, then carries it down the pipe.
//
// Ports:
//   clk, reset       clock; asynchronous active-low reset
//   d_valid          D-stage instruction valid (0 issues a bubble)
//   d_dst_sel        0 = rt, 1 = rd, 2 = LINK_REG, 3 = no write
//   d_rt, d_rd       register fields of the D-stage instruction
//   d_tnew           cycles after entering E until the result exists
//   d_rs_use/d_rt_use, d_tuse_rs/d_tuse_rt, d_rs
//                    operand read flags, Tuse values and rs index
//   flush            force a bubble into E
//   stall            hold PC and D; E receives a bubble
//   fwd_rs_sel/fwd_rt_sel
//                    0 = register file, k = forward from stage k
//   a3_bus, tnew_bus per-stage destination and remaining Tnew,
//                    stage 1 (E) in the LSBs
module dst_hazard_pipe #(
  parameter int REG_W    = 5,
  parameter int STAGES   = 3,
  parameter int TNEW_W   = 2,
  parameter int LINK_REG = 31,
  parameter int SEL_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     d_valid,
  input  logic [1:0]               d_dst_sel,
  input  logic [REG_W-1:0]         d_rt,
  input  logic [REG_W-1:0]         d_rd,
  input  logic [TNEW_W-1:0]        d_tnew,
  input  logic                     d_rs_use,
  input  logic                     d_rt_use,
  input  logic [TNEW_W-1:0]        d_tuse_rs,
  input  logic [TNEW_W-1:0]        d_tuse_rt,
  input  logic [REG_W-1:0]         d_rs,
  input  logic                     flush,
  output logic                     stall,
  output logic [SEL_W-1:0]         fwd_rs_sel,
  output logic [SEL_W-1:0]         fwd_rt_sel,
  output logic [STAGES*REG_W-1:0]  a3_bus,
  output logic [STAGES*TNEW_W-1:0] tnew_bus
);

  logic [STAGES:1][REG_W-1:0]  r_a3;
  logic [STAGES:1][TNEW_W-1:0] r_tnew;

  logic [REG_W-1:0] w_dst;
  logic             w_load;
  logic             w_stall_rs;
  logic             w_stall_rt;
  logic [SEL_W-1:0] w_sel_rs;
  logic [SEL_W-1:0] w_sel_rt;

  always_comb begin
    w_dst = '0;
    unique case (d_dst_sel)
      2'd0:    w_dst = d_rt;
      2'd1:    w_dst = d_rd;
      2'd2:    w_dst = REG_W'(LINK_REG);
      default: w_dst = '0;
    endcase
  end

  // flush and stall both turn the E load into a bubble.
  assign w_load = d_valid & ~flush & ~stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a3   <= '0;
      r_tnew <= '0;
    end else begin
      r_a3[1]   <= w_load ? w_dst : '0;
      // A non-writing instruction never carries a pending result.
      r_tnew[1] <= (w_load && w_dst != '0) ? d_tnew : '0;
      // Older stages always advance; a stall only bubbles E.
      for (int k = 2; k <= STAGES; k++) begin
        r_a3[k]   <= r_a3[k-1];
        r_tnew[k] <= (r_tnew[k-1] == '0) ? '0
                   : r_tnew[k-1] - TNEW_W'(1);
      end
    end
  end

  // Returns {stall_term, fwd_sel}. The youngest matching stage owns
  // the forward: if it is not ready yet, older copies are shadowed.
  function automatic logic [SEL_W:0] f_hazard(
    input logic                        en,
    input logic [REG_W-1:0]            src,
    input logic [TNEW_W-1:0]           tuse,
    input logic [STAGES:1][REG_W-1:0]  a3,
    input logic [STAGES:1][TNEW_W-1:0] tn
  );
    logic             st;
    logic             hit;
    logic [SEL_W-1:0] sel;
    st  = 1'b0;
    hit = 1'b0;
    sel = '0;
    if (en && src != '0) begin
      for (int k = 1; k <= STAGES; k++) begin
        if (a3[k] == src) begin
          if (tn[k] > tuse)
            st = 1'b1;
          if (!hit && tn[k] == '0)
            sel = SEL_W'(k);
          hit = 1'b1;
        end
      end
    end
    return {st, sel};
  endfunction

  assign {w_stall_rs, w_sel_rs} =
    f_hazard(d_rs_use, d_rs, d_tuse_rs, r_a3, r_tnew);
  assign {w_stall_rt, w_sel_rt} =
    f_hazard(d_rt_use, d_rt, d_tuse_rt, r_a3, r_tnew);

  assign stall      = w_stall_rs | w_stall_rt;
  assign fwd_rs_sel = w_sel_rs;
  assign fwd_rt_sel = w_sel_rt;
  assign a3_bus     = r_a3;
  assign tnew_bus   = r_tnew;

endmodule

// File: tb/tb_dst_hazard_pipe.sv
// tb_dst_hazard_pipe: scoreboard bench for dst_hazard_pipe.
// Expected output tuples are queued at drive time, compared at negedge.
module tb_dst_hazard_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [1:0]  d_dst_sel;
  logic [4:0]  d_rt;
  logic [4:0]  d_rd;
  logic [1:0]  d_tnew;
  logic        d_rs_use;
  logic        d_rt_use;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic [4:0]  d_rs;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic [14:0] a3_bus;
  logic [5:0]  tnew_bus;

  always #5 clk = ~clk;

  dst_hazard_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_dst_sel  (d_dst_sel),
    .d_rt       (d_rt),
    .d_rd       (d_rd),
    .d_tnew     (d_tnew),
    .d_rs_use   (d_rs_use),
    .d_rt_use   (d_rt_use),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_rs       (d_rs),
    .flush      (flush),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .a3_bus     (a3_bus),
    .tnew_bus   (tnew_bus)
  );

  typedef struct {
    string       nm;
    logic [25:0] v;
  } exp_t;

  typedef struct {
    string       nm;
    logic        v;
    logic [1:0]  sel;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  tn;
    logic [4:0]  rs;
    logic        ru;
    logic [1:0]  tur;
    logic        tu;
    logic [1:0]  tut;
    logic        fl;
    logic [25:0] x;
  } row_t;

  exp_t        q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [25:0] act;

  assign act = {stall, fwd_rs_sel, fwd_rt_sel, a3_bus, tnew_bus};

  // {stall, rs_sel, rt_sel, a3 W/M/E, tnew W/M/E}
  function automatic logic [25:0] ex(
    logic st, logic [1:0] rs, logic [1:0] rt,
    logic [4:0] a1, logic [4:0] a2, logic [4:0] a3,
    logic [1:0] t1, logic [1:0] t2, logic [1:0] t3);
    return {st, rs, rt, a3, a2, a1, t3, t2, t1};
  endfunction

  function automatic row_t row(
    string nm, logic v, logic [1:0] sel, logic [4:0] rt,
    logic [4:0] rd, logic [1:0] tn, logic [4:0] rs, logic ru,
    logic [1:0] tur, logic tu, logic [1:0] tut, logic fl,
    logic [25:0] x);
    row_t r;
    r.nm = nm; r.v = v; r.sel = sel; r.rt = rt; r.rd = rd;
    r.tn = tn; r.rs = rs; r.ru = ru; r.tur = tur; r.tu = tu;
    r.tut = tut; r.fl = fl; r.x = x;
    return r;
  endfunction

  task automatic drv(input row_t r);
    d_valid   = r.v;
    d_dst_sel = r.sel;
    d_rt      = r.rt;
    d_rd      = r.rd;
    d_tnew    = r.tn;
    d_rs      = r.rs;
    d_rs_use  = r.ru;
    d_tuse_rs = r.tur;
    d_rt_use  = r.tu;
    d_tuse_rt = r.tut;
    flush     = r.fl;
  endtask

  task automatic idle(input int n);
    drv(row("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drv(row("z", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
    #3;
    q.push_back('{"reset_init", ex(0,0,0, 0,0,0, 0,0,0)});
    e = q.pop_front();
    n_cmp++;
    if (act !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", e.nm, act, e.v);
    end
    drv(row("z", 1, 1, 0, 5, 1, 5, 1, 0, 0, 0, 0, '0));
    @(posedge clk); #1;
    q.push_back('{"reset_clk", ex(0,0,0, 0,0,0, 0,0,0)});
    e = q.pop_front();
    n_cmp++;
    if (act !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", e.nm, act, e.v);
    end
    @(negedge clk);
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_lw;
    row_t rows[$];
    idle(3);
    rows.push_back(row("lw_issue", 1, 0, 8, 0, 2, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 0,0,0, 0,0,0)));
    rows.push_back(row("lw_e_stall", 1, 1, 0, 10, 1, 8, 1, 1, 0, 0, 0,
                       ex(1,0,0, 8,0,0, 2,0,0)));
    rows.push_back(row("lw_m_shadow", 1, 1, 0, 10, 1, 8, 1, 1, 0, 0, 0,
                       ex(0,0,0, 0,8,0, 0,1,0)));
    rows.push_back(row("lw_w_fwd", 0, 1, 0, 10, 1, 8, 1, 1, 0, 0, 0,
                       ex(0,3,0, 10,0,8, 1,0,0)));
    rows.push_back(row("lw_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 0,10,0, 0,0,0)));
    foreach (rows[i]) begin
      drv(rows[i]);
      q.push_back('{rows[i].nm, rows[i].x});
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.nm, act, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal_and_r0;
    row_t rows[$];
    idle(3);
    rows.push_back(row("jal_issue", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 0,0,0, 0,0,0)));
    rows.push_back(row("jal_fwd", 0, 0, 0, 0, 0, 31, 1, 0, 0, 0, 0,
                       ex(0,1,0, 31,0,0, 0,0,0)));
    rows.push_back(row("r0_issue", 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 0,31,0, 0,0,0)));
    rows.push_back(row("none_issue", 1, 3, 0, 7, 3, 0, 1, 0, 1, 0, 0,
                       ex(0,0,0, 0,0,31, 0,0,0)));
    rows.push_back(row("r0_read", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0,
                       ex(0,0,0, 0,0,0, 0,0,0)));
    foreach (rows[i]) begin
      drv(rows[i]);
      q.push_back('{rows[i].nm, rows[i].x});
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.nm, act, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dual_writer;
    row_t rows[$];
    idle(3);
    rows.push_back(row("dw_a", 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 0,0,0, 0,0,0)));
    rows.push_back(row("dw_b", 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 9,0,0, 0,0,0)));
    rows.push_back(row("dw_fwd", 0, 0, 9, 0, 0, 0, 0, 0, 1, 0, 0,
                       ex(0,0,1, 9,9,0, 0,0,0)));
    rows.push_back(row("dv_a", 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 0,9,9, 0,0,0)));
    rows.push_back(row("dv_b", 1, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 9,0,9, 0,0,0)));
    // stall and flush together: stall still reported
    rows.push_back(row("dv_stall", 0, 0, 9, 0, 0, 0, 0, 0, 1, 0, 1,
                       ex(1,0,0, 9,9,0, 1,0,0)));
    rows.push_back(row("dv_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 0,9,9, 0,0,0)));
    foreach (rows[i]) begin
      drv(rows[i]);
      q.push_back('{rows[i].nm, rows[i].x});
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.nm, act, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush;
    row_t rows[$];
    idle(3);
    rows.push_back(row("fl_pre", 1, 1, 0, 12, 1, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 0,0,0, 0,0,0)));
    rows.push_back(row("fl_kill", 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 1,
                       ex(0,0,0, 12,0,0, 1,0,0)));
    rows.push_back(row("fl_resume", 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 0,12,0, 0,0,0)));
    rows.push_back(row("fl_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 5,0,12, 0,0,0)));
    foreach (rows[i]) begin
      drv(rows[i]);
      q.push_back('{rows[i].nm, rows[i].x});
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.nm, act, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    row_t rows[$];
    idle(3);
    rows.push_back(row("bb_a", 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0,
                       ex(0,0,0, 0,0,0, 0,0,0)));
    rows.push_back(row("bb_b", 1, 1, 0, 4, 0, 3, 1, 0, 0, 0, 0,
                       ex(0,1,0, 3,0,0, 0,0,0)));
    rows.push_back(row("bb_c", 1, 1, 4, 6, 0, 3, 1, 0, 1, 0, 0,
                       ex(0,2,1, 4,3,0, 0,0,0)));
    rows.push_back(row("bb_d", 0, 0, 6, 0, 0, 3, 1, 0, 1, 0, 0,
                       ex(0,3,1, 6,4,3, 0,0,0)));
    rows.push_back(row("bb_e", 0, 0, 6, 0, 0, 4, 1, 0, 1, 0, 0,
                       ex(0,3,2, 0,6,4, 0,0,0)));
    foreach (rows[i]) begin
      drv(rows[i]);
      q.push_back('{rows[i].nm, rows[i].x});
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.nm, act, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset;
    idle(3);
    drv(row("ar_lw", 1, 0, 8, 0, 2, 0, 0, 0, 0, 0, 0, '0));
    @(posedge clk); #1;
    drv(row("ar_use", 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, '0));
    q.push_back('{"ar_pre", ex(1,0,0, 8,0,0, 2,0,0)});
    @(negedge clk);
    e = q.pop_front();
    n_cmp++;
    if (act !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", e.nm, act, e.v);
    end
    #2;
    reset = 1'b0;
    q.push_back('{"ar_mid", ex(0,0,0, 0,0,0, 0,0,0)});
    #1;
    e = q.pop_front();
    n_cmp++;
    if (act !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", e.nm, act, e.v);
    end
    q.push_back('{"ar_held", ex(0,0,0, 0,0,0, 0,0,0)});
    @(posedge clk); #1;
    e = q.pop_front();
    n_cmp++;
    if (act !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", e.nm, act, e.v);
    end
    @(negedge clk);
    reset = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lw();
    test_jal_and_r0();
    test_dual_writer();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
